// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings and the length field width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_HI = 3'd1,
        LDR_LEN_LO = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_CSUM   = 3'd4,
        LDR_DONE   = 3'd5,
        LDR_ERR    = 3'd6
    } ldrState_t;

    localparam int LDR_LEN_W = 16;

    // True when the requested word count does not fit in a 2**addrW word memory.
    function automatic logic lenTooBig(input logic [LDR_LEN_W-1:0] len, input int addrW);
        return 32'(len) > (32'd1 << addrW);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four accepted bytes, MSB first, into a 32-bit word and emits a one-cycle wordValid pulse
// on the cycle after the fourth byte.
module imem_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic        lastByte,
    output logic        wordValid,
    output logic [31:0] word
);

    logic [1:0]  byteCntReg;
    logic [23:0] shiftReg;

    assign lastByte = (byteCntReg == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            byteCntReg <= '0;
            shiftReg   <= '0;
            wordValid  <= 1'b0;
            word       <= '0;
        end else begin
            wordValid <= 1'b0;
            if (clear) begin
                byteCntReg <= '0;
                shiftReg   <= '0;
            end else if (byteValid) begin
                byteCntReg <= byteCntReg + 2'd1;
                shiftReg   <= {shiftReg[15:0], byteData};
                if (lastByte) begin
                    word      <= {shiftReg, byteData};
                    wordValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> big-endian words in imem, CPU held until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    ldrState_t              stateReg, stateNext;
    logic [7:0]             lenHiReg;
    logic [LDR_LEN_W-1:0]   lenReg;
    logic [LDR_LEN_W-1:0]   lenFull;
    logic [ADDR_W:0]        wordsLoadedReg;
    logic                   startAccept;
    logic                   byteValid;
    logic                   lastByte;
    logic                   wordValid;
    logic                   lastWord;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]             csumReg;
`endif

    assign lenFull   = {lenHiReg, in_data};
    assign byteValid = (stateReg == LDR_DATA) && in_valid;
    // Compared before the pending write bumps the count, hence the +1.
    assign lastWord  = (32'(wordsLoadedReg) + 32'd1) == 32'(lenReg);

    imem_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (startAccept),
        .byteValid (byteValid),
        .byteData  (in_data),
        .lastByte  (lastByte),
        .wordValid (wordValid),
        .word      (imem_wdata)
    );

    assign imem_we      = wordValid;
    assign imem_addr    = BASE_ADDR + wordsLoadedReg[ADDR_W-1:0];
    assign words_loaded = wordsLoadedReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg <= LDR_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        startAccept = 1'b0;
        in_ready    = 1'b0;
        cpu_hold    = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (stateReg)
            LDR_IDLE: begin
                if (start) begin
                    startAccept = 1'b1;
                    stateNext   = LDR_LEN_HI;
                end
            end
            LDR_LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) stateNext = LDR_LEN_LO;
            end
            LDR_LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (lenFull == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        stateNext = LDR_CSUM;
`else
                        stateNext = LDR_DONE;
`endif
                    end else if (lenTooBig(lenFull, ADDR_W)) begin
                        stateNext = LDR_ERR;
                    end else begin
                        stateNext = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && lastByte && lastWord) begin
`ifdef IMEM_LOADER_CSUM_EN
                    stateNext = LDR_CSUM;
`else
                    stateNext = LDR_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            LDR_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) stateNext = (in_data == csumReg) ? LDR_DONE : LDR_ERR;
            end
`endif
            LDR_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) begin
                    startAccept = 1'b1;
                    stateNext   = LDR_LEN_HI;
                end
            end
            LDR_ERR: begin
                err = 1'b1;
                if (start) begin
                    startAccept = 1'b1;
                    stateNext   = LDR_LEN_HI;
                end
            end
            default: stateNext = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lenHiReg       <= '0;
            lenReg         <= '0;
            wordsLoadedReg <= '0;
        end else begin
            if (stateReg == LDR_LEN_HI && in_valid) lenHiReg <= in_data;
            if (stateReg == LDR_LEN_LO && in_valid) lenReg   <= lenFull;
            if (startAccept) begin
                wordsLoadedReg <= '0;
            end else if (wordValid) begin
                wordsLoadedReg <= wordsLoadedReg + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            csumReg <= '0;
        end else if (startAccept) begin
            csumReg <= '0;
        end else if (byteValid) begin
            csumReg <= csumReg ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected imem writes are queued as stimulus is built and
// matched against writes captured from the DUT.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    wr_t        expQ[$];
    wr_t        gotQ[$];
    logic [7:0] img[$];
    int         cycle = 0;
    int         vectors = 0;
    int         miscompares = 0;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    // Capture every write strobe with its cycle stamp.
    always @(negedge clock) begin
        cycle++;
        if (imem_we) gotQ.push_back('{addr: imem_addr, data: imem_wdata, cyc: cycle});
    end

    task automatic pushExp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        expQ.push_back('{addr: a, data: d, cyc: 0});
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Send img; gapPct>0 inserts random idle cycles. stalls counts cycles valid was high but not ready.
    task automatic sendImg(input int gapPct, output int stalls);
        stalls = 0;
        foreach (img[i]) begin
            for (int g = 0; g < 5 && gapPct > 0 && $urandom_range(99) < gapPct; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data  = img[i];
            @(negedge clock);
            for (int t = 0; t < 50 && !in_ready; t++) begin
                stalls++;
                @(negedge clock);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitEnd();
        for (int t = 0; t < 40 && !(done || err); t++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        vectors++;
        if ({in_ready, imem_we, cpu_hold, busy, done, err} !== 6'b001000 ||
            words_loaded !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b wl=%0d addr=%0h wd=%h, need 0 0 1 0 0 0 0 0 0",
                     in_ready, imem_we, cpu_hold, busy, done, err, words_loaded, imem_addr, imem_wdata);
        end
        for (int c = 0; c < 100; c++) begin
            vectors++;
            if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_quiet cycle %0d: hold=%b rdy=%b we=%b, need 1 0 0", c, cpu_hold, in_ready, imem_we);
            end
            @(negedge clock);
        end
        $display("test_reset: idle for 100 cycles checked");
    endtask

    task automatic test_load(input int gapPct, input string tag);
        int stalls;
        wr_t g, e;
        int lastCyc;
        img = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h08, 8'h00, 8'h05};
        pushExp(10'd0, 32'h3C080001);
        pushExp(10'd1, 32'h21080005);
        doStart();
        sendImg(gapPct, stalls);
        waitEnd();
        vectors++;
        if ({done, err, cpu_hold, busy} !== 4'b1000 || words_loaded !== 11'd2) begin
            miscompares++;
            $display("FAIL %s_status: done=%b err=%b hold=%b busy=%b wl=%0d, need 1 0 0 0 wl=2",
                     tag, done, err, cpu_hold, busy, words_loaded);
        end
        if (gapPct == 0) begin
            vectors++;
            if (stalls !== 0) begin
                miscompares++;
                $display("FAIL %s_back_to_back: stall cycles %0d, need 0", tag, stalls);
            end
        end
        lastCyc = -100;
        while (gotQ.size() > 0) begin
            g = gotQ.pop_front();
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL %s_extra_write: addr=%0h data=%h, need none", tag, g.addr, g.data);
            end else begin
                e = expQ.pop_front();
                if (g.addr !== e.addr || g.data !== e.data) begin
                    miscompares++;
                    $display("FAIL %s_write: got [%0h]=%h, need [%0h]=%h", tag, g.addr, g.data, e.addr, e.data);
                end
            end
            vectors++;
            if (g.cyc - lastCyc < 4) begin
                miscompares++;
                $display("FAIL %s_write_spacing: %0d cycles, need >=4", tag, g.cyc - lastCyc);
            end
            lastCyc = g.cyc;
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_write: %0d writes outstanding, need 0", tag, expQ.size());
        end
        expQ.delete();
        $display("test_load %s: gap=%0d stalls=%0d wl=%0d", tag, gapPct, stalls, words_loaded);
    endtask

    task automatic test_boundary();
        int stalls;
        img = '{8'h00, 8'h00};
        doStart();
        sendImg(0, stalls);
        waitEnd();
        vectors++;
        if ({done, err, cpu_hold, busy} !== 4'b1000 || words_loaded !== '0 || gotQ.size() != 0) begin
            miscompares++;
            $display("FAIL len_zero: done=%b err=%b hold=%b busy=%b wl=%0d writes=%0d, need 1 0 0 0 0 0",
                     done, err, cpu_hold, busy, words_loaded, gotQ.size());
        end
        $display("test_boundary: N=0 done=%b", done);
        // Bytes offered while in DONE must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            vectors++;
            if (in_ready !== 1'b0 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL done_ignores_bytes: rdy=%b done=%b, need 0 1", in_ready, done);
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        img = '{8'h04, 8'h01};
        doStart();
        sendImg(0, stalls);
        waitEnd();
        vectors++;
        if ({done, err, cpu_hold, busy} !== 4'b0110 || gotQ.size() != 0) begin
            miscompares++;
            $display("FAIL len_too_big: done=%b err=%b hold=%b busy=%b writes=%0d, need 0 1 1 0 0",
                     done, err, cpu_hold, busy, gotQ.size());
        end
        gotQ.delete();
        $display("test_boundary: N=0x0401 err=%b", err);
    endtask

    task automatic test_reset_midload();
        int stalls;
        wr_t g, e;
        img = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21};
        pushExp(10'd0, 32'h3C080001);
        doStart();
        sendImg(0, stalls);
        doReset();
        @(negedge clock);
        vectors++;
        if ({in_ready, busy, cpu_hold, done, err} !== 5'b00100 || words_loaded !== '0) begin
            miscompares++;
            $display("FAIL midload_reset_idle: rdy=%b busy=%b hold=%b done=%b err=%b wl=%0d, need 0 0 1 0 0 0",
                     in_ready, busy, cpu_hold, done, err, words_loaded);
        end
        repeat (10) @(negedge clock);
        while (gotQ.size() > 0) begin
            g = gotQ.pop_front();
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL midload_extra_write: addr=%0h data=%h, need none", g.addr, g.data);
            end else begin
                e = expQ.pop_front();
                if (g.addr !== e.addr || g.data !== e.data) begin
                    miscompares++;
                    $display("FAIL midload_write: got [%0h]=%h, need [%0h]=%h", g.addr, g.data, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL midload_missing_write: %0d outstanding, need 0", expQ.size());
        end
        expQ.delete();
        $display("test_reset_midload: aborted after 5 data bytes");
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum(input logic flip, input string tag);
        int stalls;
        wr_t g, e;
        logic [7:0] cs;
        img = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h08, 8'h00, 8'h05};
        cs = 8'h00;
        for (int i = 2; i < 10; i++) cs = cs ^ img[i];
        img.push_back(cs ^ {7'd0, flip});
        pushExp(10'd0, 32'h3C080001);
        pushExp(10'd1, 32'h21080005);
        doStart();
        sendImg(0, stalls);
        waitEnd();
        vectors++;
        if ({done, err, cpu_hold} !== (flip ? 3'b011 : 3'b100) || words_loaded !== 11'd2) begin
            miscompares++;
            $display("FAIL %s_status: done=%b err=%b hold=%b wl=%0d, need flip=%b wl=2",
                     tag, done, err, cpu_hold, words_loaded, flip);
        end
        while (gotQ.size() > 0) begin
            g = gotQ.pop_front();
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL %s_extra_write: addr=%0h data=%h, need none", tag, g.addr, g.data);
            end else begin
                e = expQ.pop_front();
                if (g.addr !== e.addr || g.data !== e.data) begin
                    miscompares++;
                    $display("FAIL %s_write: got [%0h]=%h, need [%0h]=%h", tag, g.addr, g.data, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_write: %0d outstanding, need 0", tag, expQ.size());
        end
        expQ.delete();
        $display("test_csum %s: csum byte %h done=%b err=%b", tag, img[10], done, err);
    endtask
`endif

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_load(0, "load");
        test_boundary();
        test_load(40, "random_valid");
        test_reset_midload();
        test_load(0, "reload");
`ifdef IMEM_LOADER_CSUM_EN
        test_csum(1'b0, "csum_ok");
        test_csum(1'b1, "csum_bad");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
